clockwork_param: RTL and testbench
==================================

# clockwork_param

Parametrised synchronous timekeeper. Derives its own 1 s tick from the system clock with an internal prescaler, instead of being clocked by a 1 Hz source. Keeps hours/minutes/seconds in 24 h or 12 h (AM/PM) mode and supports synchronous load with range checking, minute/hour adjust pulses and run/hold. It feeds the display and alarm logic of the digital clock and emits second and day strobes for them.

## Interface
- CLK_PER_SEC, 100_000_000, clk cycles per second; legal range ≥1. Prescaler width is clog2(CLK_PER_SEC), minimum 1.
- MODE_12H, 0, 0 = hours 0–23; 1 = hours 1–12 plus PM flag.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = time and prescaler hold.
- time_ow  in  1  synchronous time overwrite (load) strobe.
- time_in  in  17  load value, format hhhhh_mmmmmm_ssssss.
- pm_in  in  1  PM flag loaded with time_in (MODE_12H=1 only; ignored otherwise).
- inc_min  in  1  one-cycle pulse: minute +1.
- inc_hour  in  1  one-cycle pulse: hour +1.
- time_out  out  17  current time, hhhhh_mmmmmm_ssssss, registered.
- pm_out  out  1  MODE_12H=1: PM register. MODE_12H=0: hour≥12 (combinational from hour register).
- sec_pulse  out  1  high one cycle when seconds advanced from a tick.
- day_pulse  out  1  high one cycle when time rolled to midnight from a tick.
- load_err  out  1  high one cycle after a rejected time_ow.

## Operation
- Reset values:
  - 24 h mode: time 00:00:00, pm_out 0.
  - 12 h mode: time 12:00:00, PM register 0 (12 AM).
  - prescaler 0; sec_pulse, day_pulse and load_err 0.
- Priority per edge: rst > time_ow > (tick, then inc) .
- Prescaler: while run=1, counts 0..CLK_PER_SEC−1, then wraps to 0. The edge where the count equals CLK_PER_SEC−1 with run=1 is a tick. run=0 freezes the count, and no tick occurs.
- Tick: seconds +1. 59→0 carries to minutes. Minutes 59→0 carries to hours.
  - 24 h: 23→0.
  - 12 h: 11→12 toggles PM; 12→1 leaves PM unchanged.
  - Midnight is reached by 23:59:59→00:00:00 (24 h) or 11:59:59 PM→12:00:00 AM (12 h).
- time_ow load is valid when sec≤59, min≤59, and hour≤23 (24 h) or 1≤hour≤12 (12 h).
  - Valid: all fields and PM loaded; prescaler cleared to 0.
  - Invalid: no state changes (prescaler keeps counting); load_err pulses.
- inc_min: minute +1 mod 60, with no carry into hours; seconds unchanged.
- inc_hour: hour advances through the mode's hour sequence, including the 12 h PM toggle at 11→12. Minutes and seconds are unchanged; no day_pulse.
- Tick and inc in the same cycle: the tick result is computed first, then the inc is applied to it. inc_min and inc_hour together: both are applied.
- Adjust pulses work regardless of run.

## Timing
- Load and adjust latency: time_out reflects time_ow/inc on the edge where the strobe is sampled (1 cycle).
- After a valid load or rst, the first tick is CLK_PER_SEC edges later.
- sec_pulse, day_pulse and load_err are registered and high during the cycle after the causing edge.
  - sec_pulse and day_pulse coincide with the new time_out value.
  - day_pulse implies sec_pulse.
  - Strobes never assert on load, inc or reset.
- CLK_PER_SEC=1 with run=1: a tick on every edge; sec_pulse stays high continuously.
- rst mid-count discards prescaler progress; any strobes in flight are cleared the next cycle.

## Test plan
- CLK_PER_SEC=4, MODE_12H=0: load 23:59:58 → after 4 edges 23:59:59 with sec_pulse only. After 4 more edges 00:00:00 with sec_pulse and day_pulse both 1 for one cycle.
- MODE_12H=1:
  - load 11:59:59 PM=0 → one tick → 12:00:00, pm_out=1, day_pulse 0.
  - load 11:59:59 PM=1 → one tick → 12:00:00, pm_out=0, day_pulse 1.
  - load 12:59:59 → one tick → 01:00:00, PM unchanged.
- Invalid loads rejected: time_ow with sec=60, then hour=24 (24 h), then hour=0 (12 h). Each → time_out unchanged, load_err high one cycle, prescaler continues counting.
- Tick and adjust together: state 10:59:59 with tick and inc_min in the same cycle → 11:01:00. inc_min alone at 10:59:30 → 10:00:30 (no carry into hours).
- Hold: run=0 for 20 cycles mid-count → time and prescaler frozen. After run=1, the tick occurs after the remaining count, not a full CLK_PER_SEC.
- Reset: rst asserted mid-count at 05:06:07 → next cycle 00:00:00 (24 h) or 12:00:00 AM (12 h), strobes 0. First tick comes CLK_PER_SEC edges after rst is deasserted.

Source files
------------

// File: rtl/clockwork_param.sv
// -----------------------------------------------------------------------------
// clockwork_param
//
// Self-prescaled hh:mm:ss timekeeper for the digital clock. An internal
// prescaler divides the system clock down to a 1 s tick. Time is kept as
// hours/minutes/seconds, either 0-23 h or 1-12 h plus a PM flag. Supports
// a range-checked synchronous load, minute/hour adjust pulses and run/hold.
// It also emits second and day strobes for the display and alarm logic.
//
// Parameters
//   CLK_PER_SEC  clk cycles per second (>= 1)
//   MODE_12H     0: hours 0..23, 1: hours 1..12 with PM flag
//
// Ports
//   clk        in   system clock, all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   run        in   1: prescaler counts, 0: time and prescaler hold
//   time_ow    in   load strobe for time_in / pm_in
//   time_in    in   [16:0] load value hhhhh_mmmmmm_ssssss
//   pm_in      in   PM flag loaded with time_in (12 h mode only)
//   inc_min    in   one-cycle pulse, minute +1 (no carry into hours)
//   inc_hour   in   one-cycle pulse, hour +1 through the mode's sequence
//   time_out   out  [16:0] current time hhhhh_mmmmmm_ssssss (registered)
//   pm_out     out  PM register (12 h) or hour >= 12 (24 h)
//   sec_pulse  out  one cycle after a tick advanced the seconds
//   day_pulse  out  one cycle after a tick rolled the time to midnight
//   load_err   out  one cycle after a rejected time_ow
// -----------------------------------------------------------------------------

// Checker: invariants of the timekeeper outputs (simulation only).
module clockwork_param_chk #(
  parameter bit MODE_12H = 1'b0
) (
  input logic        clk,
  input logic        rst,
  input logic [16:0] time_out,
  input logic        sec_pulse,
  input logic        day_pulse
);

  // A midnight rollover is always also a seconds advance.
  a_day_has_sec : assert property (@(posedge clk) disable iff (rst)
    (day_pulse |-> sec_pulse));

  // Seconds and minutes never leave 0..59.
  a_ms_range : assert property (@(posedge clk) disable iff (rst)
    ((time_out[5:0] <= 6'd59) && (time_out[11:6] <= 6'd59)));

  // Hours stay inside the range of the selected mode.
  a_hour_range : assert property (@(posedge clk) disable iff (rst)
    (MODE_12H ? ((time_out[16:12] >= 5'd1) && (time_out[16:12] <= 5'd12))
              : (time_out[16:12] <= 5'd23)));

endmodule

module clockwork_param #(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter bit          MODE_12H    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        time_ow,
  input  logic [16:0] time_in,
  input  logic        pm_in,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [16:0] time_out,
  output logic        pm_out,
  output logic        sec_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  // CLK_PER_SEC = 1 still needs a one-bit counter (it just stays at 0).
  localparam int unsigned        PRESC_W   = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
  localparam logic [4:0]         HOUR_RST  = MODE_12H ? 5'd12 : 5'd0;

  // Next hour in the mode's sequence, returned as {pm, hour}. In 12 h mode
  // 11->12 flips AM/PM and 12->1 keeps it; in 24 h mode pm passes through.
  function automatic logic [5:0] next_hour(input logic [4:0] hour, input logic pm);
    logic [5:0] res;
    res = {pm, hour};
    if (MODE_12H) begin
      if (hour == 5'd11) begin
        res = {~pm, 5'd12};
      end else if (hour == 5'd12) begin
        res = {pm, 5'd1};
      end else begin
        res = {pm, hour + 5'd1};
      end
    end else begin
      if (hour == 5'd23) begin
        res = {pm, 5'd0};
      end else begin
        res = {pm, hour + 5'd1};
      end
    end
    return res;
  endfunction

  // Minute +1 modulo 60.
  function automatic logic [5:0] next_min(input logic [5:0] min_v);
    logic [5:0] res;
    if (min_v == 6'd59) begin
      res = 6'd0;
    end else begin
      res = min_v + 6'd1;
    end
    return res;
  endfunction

  // Range check of a load value against the selected hour mode.
  function automatic logic load_ok(input logic [16:0] v);
    logic ok;
    if ((v[5:0] > 6'd59) || (v[11:6] > 6'd59)) begin
      ok = 1'b0;
    end else if (MODE_12H) begin
      ok = (v[16:12] >= 5'd1) && (v[16:12] <= 5'd12);
    end else begin
      ok = (v[16:12] <= 5'd23);
    end
    return ok;
  endfunction

  logic [PRESC_W-1:0] presc_r;
  logic [4:0]         hour_r;
  logic [5:0]         min_r;
  logic [5:0]         sec_r;
  logic               pm_r;
  logic               sec_pulse_r;
  logic               day_pulse_r;
  logic               load_err_r;

  logic               tick_s;
  logic               load_ok_s;
  logic [PRESC_W-1:0] presc_nxt_s;
  logic [5:0]         t_sec_s;
  logic [5:0]         t_min_s;
  logic [4:0]         t_hour_s;
  logic               t_pm_s;
  logic               midnight_s;
  logic [5:0]         a_min_s;
  logic [4:0]         a_hour_s;
  logic               a_pm_s;

  // Prescaler: detect the tick and compute the next count.
  always_comb begin
    tick_s      = run && (presc_r == PRESC_MAX);
    load_ok_s   = load_ok(time_in);
    presc_nxt_s = presc_r;
    if (!run) begin
      presc_nxt_s = presc_r;
    end else if (tick_s) begin
      presc_nxt_s = {PRESC_W{1'b0}};
    end else begin
      presc_nxt_s = presc_r + PRESC_ONE;
    end
  end

  // Tick stage: seconds carry into minutes, minutes carry into hours.
  always_comb begin
    t_sec_s    = sec_r;
    t_min_s    = min_r;
    t_hour_s   = hour_r;
    t_pm_s     = pm_r;
    midnight_s = 1'b0;
    if (tick_s) begin
      if (sec_r == 6'd59) begin
        t_sec_s = 6'd0;
        if (min_r == 6'd59) begin
          t_min_s              = 6'd0;
          {t_pm_s, t_hour_s}   = next_hour(hour_r, pm_r);
          // Midnight is 23->0, or 11 PM -> 12 AM on the 12 h dial.
          midnight_s = MODE_12H ? ((hour_r == 5'd11) && pm_r) : (hour_r == 5'd23);
        end else begin
          t_min_s = min_r + 6'd1;
        end
      end else begin
        t_sec_s = sec_r + 6'd1;
      end
    end else begin
      t_sec_s    = sec_r;
      midnight_s = 1'b0;
    end
  end

  // Adjust stage: applied on top of the tick result, never carries.
  always_comb begin
    a_min_s  = t_min_s;
    a_hour_s = t_hour_s;
    a_pm_s   = t_pm_s;
    if (inc_min) begin
      a_min_s = next_min(t_min_s);
    end else begin
      a_min_s = t_min_s;
    end
    if (inc_hour) begin
      {a_pm_s, a_hour_s} = next_hour(t_hour_s, t_pm_s);
    end else begin
      a_hour_s = t_hour_s;
      a_pm_s   = t_pm_s;
    end
  end

  // State register: reset, then accepted load, otherwise tick/adjust result.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= {PRESC_W{1'b0}};
      hour_r      <= HOUR_RST;
      min_r       <= 6'd0;
      sec_r       <= 6'd0;
      pm_r        <= 1'b0;
      sec_pulse_r <= 1'b0;
      day_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else if (time_ow && load_ok_s) begin
      // An accepted load restarts the second from scratch.
      presc_r     <= {PRESC_W{1'b0}};
      hour_r      <= time_in[16:12];
      min_r       <= time_in[11:6];
      sec_r       <= time_in[5:0];
      pm_r        <= MODE_12H ? pm_in : 1'b0;
      sec_pulse_r <= 1'b0;
      day_pulse_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      // A rejected load leaves timekeeping untouched and only flags the error.
      presc_r     <= presc_nxt_s;
      hour_r      <= a_hour_s;
      min_r       <= a_min_s;
      sec_r       <= t_sec_s;
      pm_r        <= a_pm_s;
      sec_pulse_r <= tick_s;
      day_pulse_r <= midnight_s;
      load_err_r  <= time_ow;
    end
  end

  // PM indication: stored flag in 12 h mode, derived from the hour otherwise.
  always_comb begin
    if (MODE_12H) begin
      pm_out = pm_r;
    end else begin
      pm_out = (hour_r >= 5'd12);
    end
  end

  assign time_out  = {hour_r, min_r, sec_r};
  assign sec_pulse = sec_pulse_r;
  assign day_pulse = day_pulse_r;
  assign load_err  = load_err_r;

  clockwork_param_chk #(
    .MODE_12H(MODE_12H)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .time_out (time_out),
    .sec_pulse(sec_pulse),
    .day_pulse(day_pulse)
  );

endmodule

// File: tb/tb_clockwork_param.sv
// -----------------------------------------------------------------------------
// tb_clockwork_param
//
// Three instances share one set of inputs: 24 h with CLK_PER_SEC=4, 12 h with
// CLK_PER_SEC=4, and 24 h with CLK_PER_SEC=1. The reference model keeps each
// instance's time as seconds-of-day plus a prescaler count and converts to
// the display format only when comparing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clockwork_param;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst, run, time_ow, pm_in, inc_min, inc_hour;
  logic [16:0] time_in;
  logic [NDUT-1:0][16:0] t_out;
  logic [NDUT-1:0] pm_o, sp_o, dp_o, le_o;

  int checks = 0;
  int errors = 0;

  int m_tod   [NDUT];
  int m_presc [NDUT];
  bit m_sec   [NDUT];
  bit m_day   [NDUT];
  bit m_err   [NDUT];

  always #5 clk = ~clk;

  clockwork_param #(.CLK_PER_SEC(4), .MODE_12H(1'b0)) u_dut24 (
    .clk(clk), .rst(rst), .run(run), .time_ow(time_ow), .time_in(time_in),
    .pm_in(pm_in), .inc_min(inc_min), .inc_hour(inc_hour),
    .time_out(t_out[0]), .pm_out(pm_o[0]), .sec_pulse(sp_o[0]),
    .day_pulse(dp_o[0]), .load_err(le_o[0]));

  clockwork_param #(.CLK_PER_SEC(4), .MODE_12H(1'b1)) u_dut12 (
    .clk(clk), .rst(rst), .run(run), .time_ow(time_ow), .time_in(time_in),
    .pm_in(pm_in), .inc_min(inc_min), .inc_hour(inc_hour),
    .time_out(t_out[1]), .pm_out(pm_o[1]), .sec_pulse(sp_o[1]),
    .day_pulse(dp_o[1]), .load_err(le_o[1]));

  clockwork_param #(.CLK_PER_SEC(1), .MODE_12H(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .run(run), .time_ow(time_ow), .time_in(time_in),
    .pm_in(pm_in), .inc_min(inc_min), .inc_hour(inc_hour),
    .time_out(t_out[2]), .pm_out(pm_o[2]), .sec_pulse(sp_o[2]),
    .day_pulse(dp_o[2]), .load_err(le_o[2]));

  function automatic bit mode_of(input int k);
    return (k == 1);
  endfunction

  function automatic int cps_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic bit load_valid(input int k, input logic [16:0] v);
    int h, m, s;
    h = int'(v[16:12]); m = int'(v[11:6]); s = int'(v[5:0]);
    if (s > 59 || m > 59) return 1'b0;
    if (mode_of(k)) return (h >= 1 && h <= 12);
    return (h <= 23);
  endfunction

  function automatic int load_tod(input int k, input logic [16:0] v, input logic pm);
    int h;
    h = int'(v[16:12]);
    if (mode_of(k)) h = (h % 12) + (pm ? 12 : 0);
    return h * 3600 + int'(v[11:6]) * 60 + int'(v[5:0]);
  endfunction

  function automatic logic [16:0] model_time(input int k);
    int h;
    h = m_tod[k] / 3600;
    if (mode_of(k)) begin
      h = h % 12;
      if (h == 0) h = 12;
    end
    return hms(h, (m_tod[k] / 60) % 60, m_tod[k] % 60);
  endfunction

  function automatic logic model_pm(input int k);
    return (m_tod[k] / 3600) >= 12;
  endfunction

  // Advance every model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      int h, m, s;
      bit tick;
      if (rst) begin
        m_tod[k] = 0; m_presc[k] = 0; m_sec[k] = 0; m_day[k] = 0; m_err[k] = 0;
      end else if (time_ow && load_valid(k, time_in)) begin
        m_tod[k] = load_tod(k, time_in, pm_in); m_presc[k] = 0;
        m_sec[k] = 0; m_day[k] = 0; m_err[k] = 0;
      end else begin
        m_err[k] = time_ow;
        tick = run && (m_presc[k] == cps_of(k) - 1);
        if (run) m_presc[k] = tick ? 0 : m_presc[k] + 1;
        m_sec[k] = tick;
        m_day[k] = 0;
        if (tick) begin
          m_tod[k] = (m_tod[k] + 1) % 86400;
          m_day[k] = (m_tod[k] == 0);
        end
        h = m_tod[k] / 3600; m = (m_tod[k] / 60) % 60; s = m_tod[k] % 60;
        if (inc_min)  m = (m + 1) % 60;
        if (inc_hour) h = (h + 1) % 24;
        m_tod[k] = h * 3600 + m * 60 + s;
      end
    end
  endtask

  task automatic clock_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input logic [16:0] v, input logic pm);
    time_ow = 1'b1; time_in = v; pm_in = pm;
    clock_cycle();
    time_ow = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    clock_cycle(); clock_cycle();
    rst = 1'b0;
    checks++; if (t_out[0] !== hms(0, 0, 0)) begin errors++; $display("FAIL reset_time24: got %h expected %h", t_out[0], hms(0, 0, 0)); end
    checks++; if (t_out[1] !== hms(12, 0, 0)) begin errors++; $display("FAIL reset_time12: got %h expected %h", t_out[1], hms(12, 0, 0)); end
    checks++; if (t_out[2] !== hms(0, 0, 0)) begin errors++; $display("FAIL reset_time_c1: got %h expected %h", t_out[2], hms(0, 0, 0)); end
    checks++; if ({pm_o, sp_o, dp_o, le_o} !== 12'h000) begin errors++; $display("FAIL reset_flags: got %h expected 000", {pm_o, sp_o, dp_o, le_o}); end
  endtask

  task automatic test_rollover_24();
    logic [16:0] exp_t;
    logic exp_sp, exp_dp;
    do_load(hms(23, 59, 58), 1'b0);
    checks++; if ({t_out[0], sp_o[0]} !== {hms(23, 59, 58), 1'b0}) begin errors++; $display("FAIL load24: got %h expected %h", {t_out[0], sp_o[0]}, {hms(23, 59, 58), 1'b0}); end
    for (int i = 1; i <= 9; i++) begin
      clock_cycle();
      exp_t  = (i < 4) ? hms(23, 59, 58) : (i < 8) ? hms(23, 59, 59) : hms(0, 0, 0);
      exp_sp = (i == 4) || (i == 8);
      exp_dp = (i == 8);
      checks++;
      if ({t_out[0], sp_o[0], dp_o[0]} !== {exp_t, exp_sp, exp_dp}) begin
        errors++;
        $display("FAIL rollover24 edge %0d: got t=%h sp=%b dp=%b expected t=%h sp=%b dp=%b", i, t_out[0], sp_o[0], dp_o[0], exp_t, exp_sp, exp_dp);
      end
    end
  endtask

  task automatic test_12h_rollover();
    logic [16:0] ld [3];
    logic        ldpm [3];
    logic [16:0] ex [3];
    logic        expm [3];
    logic        exdp [3];
    ld[0] = hms(11, 59, 59); ldpm[0] = 1'b0; ex[0] = hms(12, 0, 0); expm[0] = 1'b1; exdp[0] = 1'b0;
    ld[1] = hms(11, 59, 59); ldpm[1] = 1'b1; ex[1] = hms(12, 0, 0); expm[1] = 1'b0; exdp[1] = 1'b1;
    ld[2] = hms(12, 59, 59); ldpm[2] = 1'b1; ex[2] = hms(1, 0, 0);  expm[2] = 1'b1; exdp[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      do_load(ld[c], ldpm[c]);
      for (int i = 0; i < 4; i++) clock_cycle();
      checks++;
      if ({t_out[1], pm_o[1], sp_o[1], dp_o[1]} !== {ex[c], expm[c], 1'b1, exdp[c]}) begin
        errors++;
        $display("FAIL rollover12 case %0d: got t=%h pm=%b sp=%b dp=%b expected t=%h pm=%b sp=1 dp=%b", c, t_out[1], pm_o[1], sp_o[1], dp_o[1], ex[c], expm[c], exdp[c]);
      end
    end
  endtask

  task automatic test_invalid_loads();
    do_load(hms(5, 6, 7), 1'b0);
    clock_cycle();
    do_load(hms(5, 6, 60), 1'b0);
    checks++; if ({t_out[0], t_out[1], le_o[1:0], sp_o[1:0]} !== {hms(5, 6, 7), hms(5, 6, 7), 2'b11, 2'b00}) begin errors++; $display("FAIL bad_sec: got %h expected %h", {t_out[0], t_out[1], le_o[1:0], sp_o[1:0]}, {hms(5, 6, 7), hms(5, 6, 7), 2'b11, 2'b00}); end
    clock_cycle();
    checks++; if ({t_out[0], le_o[1:0], sp_o[0]} !== {hms(5, 6, 7), 2'b00, 1'b0}) begin errors++; $display("FAIL bad_sec_after: got %h expected %h", {t_out[0], le_o[1:0], sp_o[0]}, {hms(5, 6, 7), 2'b00, 1'b0}); end
    clock_cycle();
    checks++; if ({t_out[0], t_out[1], sp_o[0]} !== {hms(5, 6, 8), hms(5, 6, 8), 1'b1}) begin errors++; $display("FAIL bad_sec_tick: got %h expected %h", {t_out[0], t_out[1], sp_o[0]}, {hms(5, 6, 8), hms(5, 6, 8), 1'b1}); end
    do_load(hms(24, 0, 0), 1'b0);
    checks++; if ({t_out[0], le_o[1:0]} !== {hms(5, 6, 8), 2'b11}) begin errors++; $display("FAIL bad_hour24: got %h expected %h", {t_out[0], le_o[1:0]}, {hms(5, 6, 8), 2'b11}); end
    do_load(hms(0, 10, 20), 1'b0);
    checks++; if ({t_out[1], le_o[1]} !== {hms(5, 6, 8), 1'b1}) begin errors++; $display("FAIL bad_hour12: got %h expected %h", {t_out[1], le_o[1]}, {hms(5, 6, 8), 1'b1}); end
    checks++; if ({t_out[0], le_o[0]} !== {hms(0, 10, 20), 1'b0}) begin errors++; $display("FAIL hour0_24: got %h expected %h", {t_out[0], le_o[0]}, {hms(0, 10, 20), 1'b0}); end
    clock_cycle();
    checks++; if ({t_out[1], sp_o[1]} !== {hms(5, 6, 8), 1'b0}) begin errors++; $display("FAIL bad_hour12_hold: got %h expected %h", {t_out[1], sp_o[1]}, {hms(5, 6, 8), 1'b0}); end
    clock_cycle();
    checks++; if ({t_out[1], sp_o[1]} !== {hms(5, 6, 9), 1'b1}) begin errors++; $display("FAIL bad_hour12_tick: got %h expected %h", {t_out[1], sp_o[1]}, {hms(5, 6, 9), 1'b1}); end
  endtask

  task automatic test_tick_and_adjust();
    do_load(hms(10, 59, 59), 1'b0);
    for (int i = 0; i < 3; i++) clock_cycle();
    inc_min = 1'b1; clock_cycle(); inc_min = 1'b0;
    checks++; if ({t_out[0], t_out[1], sp_o[1:0]} !== {hms(11, 1, 0), hms(11, 1, 0), 2'b11}) begin errors++; $display("FAIL tick_inc_min: got %h expected %h", {t_out[0], t_out[1], sp_o[1:0]}, {hms(11, 1, 0), hms(11, 1, 0), 2'b11}); end
    do_load(hms(10, 59, 30), 1'b0);
    inc_min = 1'b1; clock_cycle(); inc_min = 1'b0;
    checks++; if ({t_out[0], t_out[1], sp_o[1:0]} !== {hms(10, 0, 30), hms(10, 0, 30), 2'b00}) begin errors++; $display("FAIL inc_min_nocarry: got %h expected %h", {t_out[0], t_out[1], sp_o[1:0]}, {hms(10, 0, 30), hms(10, 0, 30), 2'b00}); end
    inc_min = 1'b1; inc_hour = 1'b1; clock_cycle(); inc_min = 1'b0; inc_hour = 1'b0;
    checks++; if ({t_out[0], t_out[1]} !== {hms(11, 1, 30), hms(11, 1, 30)}) begin errors++; $display("FAIL inc_both: got %h expected %h", {t_out[0], t_out[1]}, {hms(11, 1, 30), hms(11, 1, 30)}); end
    do_load(hms(11, 20, 0), 1'b1);
    inc_hour = 1'b1; clock_cycle(); inc_hour = 1'b0;
    checks++; if ({t_out[1], pm_o[1], dp_o[1]} !== {hms(12, 20, 0), 1'b0, 1'b0}) begin errors++; $display("FAIL inc_hour12_pm: got %h expected %h", {t_out[1], pm_o[1], dp_o[1]}, {hms(12, 20, 0), 1'b0, 1'b0}); end
    checks++; if ({t_out[0], pm_o[0]} !== {hms(12, 20, 0), 1'b1}) begin errors++; $display("FAIL inc_hour24: got %h expected %h", {t_out[0], pm_o[0]}, {hms(12, 20, 0), 1'b1}); end
  endtask

  task automatic test_hold();
    do_load(hms(1, 2, 3), 1'b0);
    clock_cycle(); clock_cycle();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clock_cycle();
      checks++;
      if ({t_out[0], t_out[2], sp_o[0], sp_o[2]} !== {hms(1, 2, 3), hms(1, 2, 5), 2'b00}) begin
        errors++;
        $display("FAIL hold cycle %0d: got %h expected %h", i, {t_out[0], t_out[2], sp_o[0], sp_o[2]}, {hms(1, 2, 3), hms(1, 2, 5), 2'b00});
      end
    end
    run = 1'b1;
    clock_cycle();
    checks++; if ({t_out[0], sp_o[0]} !== {hms(1, 2, 3), 1'b0}) begin errors++; $display("FAIL hold_resume_early: got %h expected %h", {t_out[0], sp_o[0]}, {hms(1, 2, 3), 1'b0}); end
    clock_cycle();
    checks++; if ({t_out[0], sp_o[0]} !== {hms(1, 2, 4), 1'b1}) begin errors++; $display("FAIL hold_resume_tick: got %h expected %h", {t_out[0], sp_o[0]}, {hms(1, 2, 4), 1'b1}); end
  endtask

  task automatic test_reset_mid();
    do_load(hms(5, 6, 7), 1'b0);
    clock_cycle(); clock_cycle();
    rst = 1'b1; clock_cycle(); rst = 1'b0;
    checks++; if ({t_out[0], t_out[1], pm_o[1]} !== {hms(0, 0, 0), hms(12, 0, 0), 1'b0}) begin errors++; $display("FAIL rst_mid_time: got %h expected %h", {t_out[0], t_out[1], pm_o[1]}, {hms(0, 0, 0), hms(12, 0, 0), 1'b0}); end
    checks++; if ({sp_o, dp_o, le_o} !== 9'h000) begin errors++; $display("FAIL rst_mid_strobes: got %h expected 000", {sp_o, dp_o, le_o}); end
    for (int i = 1; i <= 4; i++) begin
      clock_cycle();
      checks++;
      if ({t_out[0], t_out[1], sp_o[0]} !== ((i < 4) ? {hms(0, 0, 0), hms(12, 0, 0), 1'b0} : {hms(0, 0, 1), hms(12, 0, 1), 1'b1})) begin
        errors++;
        $display("FAIL rst_first_tick edge %0d: got %h", i, {t_out[0], t_out[1], sp_o[0]});
      end
    end
  endtask

  task automatic test_cps1();
    for (int i = 0; i < 5; i++) begin
      clock_cycle();
      checks++;
      if ({t_out[2], sp_o[2]} !== {model_time(2), 1'b1}) begin
        errors++;
        $display("FAIL cps1 cycle %0d: got %h expected %h", i, {t_out[2], sp_o[2]}, {model_time(2), 1'b1});
      end
    end
  endtask

  task automatic test_random();
    int h, m, s;
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(99) == 0);
      run      = ($urandom_range(7) != 0);
      time_ow  = ($urandom_range(11) == 0);
      inc_min  = ($urandom_range(9) == 0);
      inc_hour = ($urandom_range(9) == 0);
      pm_in    = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) h = ($urandom_range(2) == 0) ? 23 : ($urandom_range(1) == 0) ? 11 : 12;
      else h = $urandom_range(31);
      m = ($urandom_range(1) == 0) ? 59 : $urandom_range(63);
      s = ($urandom_range(1) == 0) ? $urandom_range(59, 55) : $urandom_range(63);
      time_in = hms(h, m, s);
      clock_cycle();
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if ({t_out[k], pm_o[k], sp_o[k], dp_o[k], le_o[k]} !== {model_time(k), model_pm(k), m_sec[k], m_day[k], m_err[k]}) begin
          errors++;
          $display("FAIL random cyc %0d dut %0d: got t=%h pm=%b sp=%b dp=%b le=%b expected t=%h pm=%b sp=%b dp=%b le=%b",
                   c, k, t_out[k], pm_o[k], sp_o[k], dp_o[k], le_o[k], model_time(k), model_pm(k), m_sec[k], m_day[k], m_err[k]);
        end
      end
    end
    rst = 1'b0; time_ow = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; time_ow = 1'b0; time_in = 17'd0;
    pm_in = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      m_tod[k] = 0; m_presc[k] = 0; m_sec[k] = 0; m_day[k] = 0; m_err[k] = 0;
    end
    test_reset();
    test_rollover_24();
    test_12h_rollover();
    test_invalid_loads();
    test_tick_and_adjust();
    test_hold();
    test_reset_mid();
    test_cps1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
